// File: rtl/wb_can_fanout_bridge.sv
// wb_can_fanout_bridge: 32-bit pipelined Wishbone debug-bus slave fanned out to
// NUM_CH 8-bit classic-Wishbone CAN cores. Decodes a channel from the address,
// rebases the local register address, narrows data, allows one transaction in
// flight, bounds each access with an ack timeout and registers core interrupts.
module wb_can_fanout_bridge #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CH_ADDR_BITS   = 8,
    parameter int unsigned ADDR_OFFSET    = 1,
    parameter int unsigned TIMEOUT_CLKS   = 255,
    parameter int unsigned IRQ_ACTIVE_LOW = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    input  logic                      i_wb_we,
    input  logic [31:0]               i_wb_addr,
    input  logic [31:0]               i_wb_data,
    output logic                      o_wb_ack,
    output logic                      o_wb_err,
    output logic                      o_wb_stall,
    output logic [31:0]               o_wb_data,
    output logic [NUM_CH-1:0]         o_ch_cyc,
    output logic [NUM_CH-1:0]         o_ch_stb,
    output logic                      o_ch_we,
    output logic [CH_ADDR_BITS-1:0]   o_ch_addr,
    output logic [7:0]                o_ch_data,
    input  logic [8*NUM_CH-1:0]       i_ch_data,
    input  logic [NUM_CH-1:0]         i_ch_ack,
    input  logic [NUM_CH-1:0]         i_ch_irq,
    output logic [NUM_CH-1:0]         o_irq,
    output logic                      o_irq_any
);

    localparam int unsigned SEL_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned HI_LSB   = CH_ADDR_BITS + SEL_BITS;

    localparam logic [CH_ADDR_BITS-1:0] LP_OFFSET  = ADDR_OFFSET[CH_ADDR_BITS-1:0];
    localparam logic [15:0]             LP_TIMEOUT = TIMEOUT_CLKS[15:0];
    localparam logic [NUM_CH-1:0]       LP_IRQ_POL = {NUM_CH{IRQ_ACTIVE_LOW[0]}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]              r_state;
    logic [SEL_BITS-1:0]     r_sel;
    logic [15:0]             r_cnt;
    logic                    r_ack;
    logic                    r_err;
    logic                    r_stall;
    logic [7:0]              r_rdata;
    logic [NUM_CH-1:0]       r_stb;
    logic                    r_we;
    logic [CH_ADDR_BITS-1:0] r_addr;
    logic [7:0]              r_wdata;
    logic [NUM_CH-1:0]       r_irq;
    logic                    r_irq_any;

    logic [SEL_BITS-1:0]     w_sel;
    logic [CH_ADDR_BITS-1:0] w_local;
    logic [31:0]             w_hi_bits;
    logic                    w_addr_bad;
    logic [NUM_CH-1:0]       w_onehot;
    logic                    w_sel_ack;
    logic [7:0]              w_sel_data;
    logic [15:0]             w_cnt_inc;
    logic [NUM_CH-1:0]       w_irq_next;
    logic                    w_unused_wdata;

    // Address decode of the incoming request
    assign w_sel      = i_wb_addr[CH_ADDR_BITS +: SEL_BITS];
    assign w_local    = i_wb_addr[CH_ADDR_BITS-1:0] - LP_OFFSET;
    assign w_hi_bits  = i_wb_addr >> HI_LSB;
    assign w_addr_bad = (w_hi_bits != '0) || (32'(w_sel) >= NUM_CH);

    // Channel-specific response of the latched target
    assign w_sel_ack  = i_ch_ack[r_sel];
    assign w_sel_data = i_ch_data[{r_sel, 3'b000} +: 8];
    assign w_cnt_inc  = r_cnt + 16'd1;

    assign w_irq_next     = i_ch_irq ^ LP_IRQ_POL;
    assign w_unused_wdata = ^i_wb_data[31:8];

    // One-hot strobe pattern for the decoded channel
    always_comb begin
        w_onehot = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            w_onehot[n] = (32'(w_sel) == n);
        end
    end

    // Transaction FSM: accept, wait for ack/timeout/abort, emit one response pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
            r_rdata <= '0;
            r_stb   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_stall <= 1'b0;
                    if (i_wb_cyc && i_wb_stb) begin
                        r_we    <= i_wb_we;
                        r_wdata <= i_wb_data[7:0];
                        r_addr  <= w_local;
                        r_sel   <= w_sel;
                        r_cnt   <= '0;
                        r_stall <= 1'b1;
                        if (w_addr_bad) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_stb   <= w_onehot;
                            r_state <= S_BUSY;
                        end
                    end
                end
                // ack beats timeout beats abort when they land on the same edge
                S_BUSY: begin
                    if (w_sel_ack) begin
                        r_stb <= '0;
                        if (!r_we) begin
                            r_rdata <= w_sel_data;
                        end
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (w_cnt_inc == LP_TIMEOUT) begin
                        r_stb   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (!i_wb_cyc) begin
                        r_stb   <= '0;
                        r_stall <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP: begin
                    r_stall <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_stb   <= '0;
                    r_stall <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Interrupt normalisation to active-high, registered
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_irq     <= '0;
            r_irq_any <= 1'b0;
        end else begin
            r_irq     <= w_irq_next;
            r_irq_any <= |w_irq_next;
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_err   = r_err;
    assign o_wb_stall = r_stall;
    assign o_wb_data  = {24'd0, r_rdata};
    assign o_ch_cyc   = r_stb;
    assign o_ch_stb   = r_stb;
    assign o_ch_we    = r_we;
    assign o_ch_addr  = r_addr;
    assign o_ch_data  = r_wdata;
    assign o_irq      = r_irq;
    assign o_irq_any  = r_irq_any;

endmodule

// File: tb/tb_wb_can_fanout_bridge.sv
// Self-checking bench for wb_can_fanout_bridge: directed cases plus randomized
// transactions compared against an outcome model derived from event timing.
module tb_wb_can_fanout_bridge;

    localparam int NCH   = 4;
    localparam int TMO   = 16;
    localparam int OFS   = 1;
    localparam int NEVER = 1000;

    logic        i_clk;
    logic        i_reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic        o_wb_ack, o_wb_err, o_wb_stall;
    logic [31:0] o_wb_data;
    logic [NCH-1:0] o_ch_cyc, o_ch_stb;
    logic        o_ch_we;
    logic [7:0]  o_ch_addr, o_ch_data;
    logic [8*NCH-1:0] i_ch_data;
    logic [NCH-1:0] i_ch_ack, i_ch_irq, o_irq;
    logic        o_irq_any;

    int n_tests = 0;
    int n_fail  = 0;
    bit irq_rand = 1'b1;
    logic [7:0] exp_rdata = 8'h00;

    wb_can_fanout_bridge #(
        .NUM_CH(NCH), .CH_ADDR_BITS(8), .ADDR_OFFSET(OFS),
        .TIMEOUT_CLKS(TMO), .IRQ_ACTIVE_LOW(1)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_stall(o_wb_stall),
        .o_wb_data(o_wb_data),
        .o_ch_cyc(o_ch_cyc), .o_ch_stb(o_ch_stb), .o_ch_we(o_ch_we),
        .o_ch_addr(o_ch_addr), .o_ch_data(o_ch_data),
        .i_ch_data(i_ch_data), .i_ch_ack(i_ch_ack), .i_ch_irq(i_ch_irq),
        .o_irq(o_irq), .o_irq_any(o_irq_any)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; interrupt outputs must equal the inverted lines held before the edge
    task automatic tick();
        logic [NCH-1:0] drv;
        logic [NCH-1:0] exp_irq;
        drv = i_ch_irq;
        @(posedge i_clk);
        #1;
        exp_irq = ~drv;
        check_eq("irq", o_irq, exp_irq);
        check_eq("irq_any", o_irq_any, (exp_irq != 0));
        if (irq_rand) i_ch_irq = NCH'($urandom);
    endtask

    // One upstream access. ack_cyc: cycle in which the selected core acks
    // (strobe first high in cycle 1); abort_cyc: cycle in which cyc goes low.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int ack_cyc, input int abort_cyc, input logic [7:0] rdata);
        bit             valid;
        int             sel;
        int             e;
        int             kind;   // 0 ack, 1 err, 2 silent abort
        logic [7:0]     loc;
        logic [NCH-1:0] exp_stb;
        logic [NCH-1:0] ack_v;
        logic [8*NCH-1:0] data_v;
        valid = (addr < 32'(NCH * 256));
        sel   = int'(addr / 256);
        loc   = 8'((addr % 256 + 256 - OFS) % 256);
        if (!valid) begin
            e = 0; kind = 1;
        end else if (ack_cyc <= TMO && ack_cyc <= abort_cyc) begin
            e = ack_cyc; kind = 0;
        end else if (TMO <= abort_cyc) begin
            e = TMO; kind = 1;
        end else begin
            e = abort_cyc; kind = 2;
        end

        check_eq("idle_stall", o_wb_stall, 0);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_addr = addr; i_wb_data = wdata; i_ch_ack = '0;
        tick();
        i_wb_stb = 1'b0;
        for (int c = 1; c <= e + 2; c++) begin
            exp_stb = '0;
            if (valid && c <= e) exp_stb[sel] = 1'b1;
            if (c == e + 1 && kind == 0 && !we) exp_rdata = rdata;
            check_eq("ch_stb", o_ch_stb, exp_stb);
            check_eq("ch_cyc", o_ch_cyc, exp_stb);
            check_eq("wb_ack", o_wb_ack, (c == e + 1 && kind == 0));
            check_eq("wb_err", o_wb_err, (c == e + 1 && kind == 1));
            check_eq("wb_stall", o_wb_stall, (c <= e) || (c == e + 1 && kind != 2));
            check_eq("wb_data", o_wb_data, {24'd0, exp_rdata});
            if (c == 1) begin
                check_eq("ch_addr", o_ch_addr, loc);
                check_eq("ch_we", o_ch_we, we);
                check_eq("ch_data", o_ch_data, wdata[7:0]);
            end
            if (c == e + 2) break;
            i_wb_cyc = (c < abort_cyc) && (c <= e);
            ack_v  = NCH'($urandom);
            data_v = {$urandom};
            if (valid) begin
                ack_v[sel] = (c == ack_cyc);
                data_v[8*sel +: 8] = rdata;
            end
            i_ch_ack  = ack_v;
            i_ch_data = data_v;
            tick();
        end
        i_wb_cyc = 1'b0;
        i_ch_ack = '0;
    endtask

    initial begin
        logic [31:0] addr;
        int          a, d, r;
        i_reset = 1'b1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_addr = '0; i_wb_data = '0;
        i_ch_data = '0; i_ch_ack = '0; i_ch_irq = 4'hF;
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_ack", o_wb_ack, 0);
        check_eq("rst_err", o_wb_err, 0);
        check_eq("rst_stall", o_wb_stall, 0);
        check_eq("rst_data", o_wb_data, 0);
        check_eq("rst_stb", o_ch_stb, 0);
        check_eq("rst_irq", o_irq, 0);
        i_reset = 1'b0;
        tick();

        // Directed cases
        run_txn(32'h0000_0005, 1'b0, 32'h0, 3, NEVER, 8'hA5);
        run_txn(32'h0000_0200, 1'b1, 32'h1234_5678, 2, NEVER, 8'h3C);
        run_txn(32'h0000_0400, 1'b0, 32'h0, 1, NEVER, 8'h11);
        run_txn(32'h0001_0000, 1'b1, 32'hFF, 1, NEVER, 8'h22);
        run_txn(32'h0000_0310, 1'b0, 32'h0, NEVER, NEVER, 8'h77);
        run_txn(32'h0000_0120, 1'b0, 32'h0, 1, NEVER, 8'h5A);
        run_txn(32'h0000_0101, 1'b0, 32'h0, 4, 3, 8'hC3);
        run_txn(32'h0000_0002, 1'b0, 32'h0, TMO, NEVER, 8'h81);
        run_txn(32'h0000_0003, 1'b0, 32'h0, TMO + 1, NEVER, 8'h18);
        run_txn(32'h0000_0204, 1'b0, 32'h0, 2, 2, 8'h66);

        // Asynchronous reset in the middle of a BUSY access
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = 32'h0000_0105; i_wb_data = 32'h99;
        tick();
        i_wb_stb = 1'b0;
        tick();
        check_eq("busy_stb", o_ch_stb, 4'b0010);
        #3 i_reset = 1'b1;
        #1;
        check_eq("arst_stb", o_ch_stb, 0);
        check_eq("arst_cyc", o_ch_cyc, 0);
        check_eq("arst_stall", o_wb_stall, 0);
        check_eq("arst_data", o_wb_data, 0);
        check_eq("arst_addr", o_ch_addr, 0);
        check_eq("arst_we", o_ch_we, 0);
        check_eq("arst_chdata", o_ch_data, 0);
        check_eq("arst_irq", {o_irq_any, o_irq}, 0);
        #1 i_reset = 1'b0;
        i_wb_cyc = 1'b0;
        exp_rdata = 8'h00;
        tick();
        check_eq("post_rst_ack", o_wb_ack, 0);
        check_eq("post_rst_stb", o_ch_stb, 0);
        run_txn(32'h0000_0333, 1'b0, 32'h0, 2, NEVER, 8'hE7);

        // Directed interrupt sequence
        irq_rand = 1'b0;
        i_ch_irq = 4'b1111;
        tick();
        i_ch_irq = 4'b1101;
        tick();
        check_eq("irq_ch1", o_irq, 4'b0010);
        check_eq("irq_any_ch1", o_irq_any, 1);
        i_ch_irq = 4'b1111;
        tick();
        check_eq("irq_clear", o_irq, 4'b0000);
        check_eq("irq_any_clear", o_irq_any, 0);
        irq_rand = 1'b1;

        // Randomized transactions
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) addr = $urandom;
            else if (r == 1) addr = (32'($urandom_range(4, 7)) << 8) | 32'($urandom_range(0, 255));
            else addr = 32'($urandom_range(0, 1023));
            a = $urandom_range(1, TMO + 2);
            d = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TMO + 1) : NEVER;
            run_txn(addr, 1'($urandom), $urandom, a, d, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
